// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler:
//   - scheduler state encoding
//   - ASCII rate-change codes and the baud rates they select
//   - divisor helper (clocks per bit from clock frequency and baud)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_GAP,
    ST_HOLD
  } state_t;

  localparam logic [7:0] RATE_CODE_9600      = 8'h31;  // '1'
  localparam logic [7:0] RATE_CODE_57600     = 8'h35;  // '5'
  localparam logic [7:0] RATE_CODE_115200_LC = 8'h61;  // 'a'
  localparam logic [7:0] RATE_CODE_115200_UC = 8'h41;  // 'A'

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  // Clocks per bit, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Two-way round-robin arbiter.
//   req      : request vector {req1, req0}
//   ptr      : favoured requester (0 = req0, 1 = req1); wins a tie
//   advance  : release strobe; the pointer moves to the side not in owner
//   owner    : one-hot grant currently being released
//   grant    : one-hot grant for the current request vector
//   ptr_next : pointer value for the next cycle
module uart_rr_arbiter (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  input  logic [1:0] owner,
  output logic [1:0] grant,
  output logic       ptr_next
);

  always_comb begin
    grant = '0;
    if (ptr == 1'b0) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (advance) begin
      if (owner[0])      ptr_next = 1'b1;
      else if (owner[1]) ptr_next = 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX core between two byte-stream requesters with
// packet-level round-robin arbitration, inter-byte gap insertion, per-grant
// byte limit, mid-packet hold timeout and between-packet baud rate changes.
//   clk, reset                : system clock, async active-high reset
//   iREQx_VALID/DATA/LAST     : requester byte stream (x = 0 echo, 1 bulk)
//   oREQx_READY               : byte accepted this cycle
//   oTX_START/oTX_DATA        : start pulse and byte to the TX core
//   iTX_DONE                  : TX core finished the byte
//   iRATE/iRATE_VALID         : ASCII rate-change request
//   oBAUD_DIV                 : clocks per bit for the TX core
//   oGRANT                    : one-hot current grant, 00 = none
//   oBUSY                     : high outside IDLE
//   oRATE_ERR                 : pulse for an unsupported rate code
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned MAX_PKT      = 64,
  parameter int unsigned HOLD_TIMEOUT = 1024,
  parameter int unsigned DIV_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iREQ0_VALID,
  input  logic [7:0]       iREQ0_DATA,
  input  logic             iREQ0_LAST,
  output logic             oREQ0_READY,
  input  logic             iREQ1_VALID,
  input  logic [7:0]       iREQ1_DATA,
  input  logic             iREQ1_LAST,
  output logic             oREQ1_READY,
  output logic             oTX_START,
  output logic [7:0]       oTX_DATA,
  input  logic             iTX_DONE,
  input  logic [7:0]       iRATE,
  input  logic             iRATE_VALID,
  output logic [DIV_W-1:0] oBAUD_DIV,
  output logic [1:0]       oGRANT,
  output logic             oBUSY,
  output logic             oRATE_ERR
);

  localparam int unsigned CNT_W  = $clog2(MAX_PKT) + 1;
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(baud_div(CLK_HZ, BAUD_9600));
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(baud_div(CLK_HZ, BAUD_57600));
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(baud_div(CLK_HZ, BAUD_115200));

  state_t            state_q,    state_d;
  logic [1:0]        grant_q,    grant_d;
  logic              ptr_q,      ptr_d;
  logic              ready0_q,   ready0_d;
  logic              ready1_q,   ready1_d;
  logic              start_q,    start_d;
  logic [7:0]        tx_data_q,  tx_data_d;
  logic              last_q,     last_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pend_q,     pend_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic [DIV_W-1:0]  baud_div_q, baud_div_d;
  logic              busy_q,     busy_d;
  logic              rate_err_q, rate_err_d;

  logic             gnt_valid;
  logic             gap_done;
  logic             pkt_end;
  logic             hold_to;
  logic             release_grant;
  logic             apply_rate;
  logic             code_ok;
  logic [DIV_W-1:0] code_div;
  logic [1:0]       arb_grant;
  logic             arb_ptr_next;

  uart_rr_arbiter u_arb (
    .req      ({iREQ1_VALID, iREQ0_VALID}),
    .ptr      (ptr_q),
    .advance  (release_grant),
    .owner    (grant_q),
    .grant    (arb_grant),
    .ptr_next (arb_ptr_next)
  );

  always_comb begin
    gnt_valid = 1'b0;
    if (grant_q[0])      gnt_valid = iREQ0_VALID;
    else if (grant_q[1]) gnt_valid = iREQ1_VALID;
  end

  always_comb begin
    gap_done      = (state_q == ST_GAP) && (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
    pkt_end       = last_q || (byte_cnt_q == CNT_W'(MAX_PKT));
    hold_to       = (state_q == ST_HOLD) && !gnt_valid &&
                    (hold_cnt_q == HOLD_W'(HOLD_TIMEOUT - 1));
    release_grant = (gap_done && pkt_end) || hold_to;
    apply_rate    = (state_q == ST_IDLE) && pend_q && (grant_q == 2'b00);
  end

  always_comb begin
    code_ok  = 1'b1;
    code_div = DIV_9600;
    case (iRATE)
      RATE_CODE_9600:      code_div = DIV_9600;
      RATE_CODE_57600:     code_div = DIV_57600;
      RATE_CODE_115200_LC: code_div = DIV_115200;
      RATE_CODE_115200_UC: code_div = DIV_115200;
      default:             code_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = arb_ptr_next;
    ready0_d   = 1'b0;
    ready1_d   = 1'b0;
    start_d    = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hold_cnt_d = hold_cnt_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    baud_div_d = baud_div_q;
    rate_err_d = 1'b0;

    // Apply before capture so a request arriving in the apply cycle stays pending.
    if (apply_rate) begin
      baud_div_d = pend_div_q;
      pend_d     = 1'b0;
    end
    if (iRATE_VALID) begin
      if (code_ok) begin
        pend_d     = 1'b1;
        pend_div_d = code_div;
      end else begin
        rate_err_d = 1'b1;
      end
    end

    // Byte capture happens on entry to LOAD so that oTX_DATA, READY and
    // oTX_START are all registered and valid throughout the LOAD cycle.
    case (state_q)
      ST_IDLE: begin
        if (!apply_rate && (arb_grant != 2'b00)) begin
          grant_d    = arb_grant;
          state_d    = ST_LOAD;
          start_d    = 1'b1;
          ready0_d   = arb_grant[0];
          ready1_d   = arb_grant[1];
          tx_data_d  = arb_grant[1] ? iREQ1_DATA : iREQ0_DATA;
          last_d     = arb_grant[1] ? iREQ1_LAST : iREQ0_LAST;
          byte_cnt_d = CNT_W'(1);
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iTX_DONE) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          if (pkt_end) begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_HOLD: begin
        if (gnt_valid) begin
          state_d    = ST_LOAD;
          start_d    = 1'b1;
          ready0_d   = grant_q[0];
          ready1_d   = grant_q[1];
          tx_data_d  = grant_q[1] ? iREQ1_DATA : iREQ0_DATA;
          last_d     = grant_q[1] ? iREQ1_LAST : iREQ0_LAST;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end else if (hold_to) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= 1'b0;
      ready0_q   <= 1'b0;
      ready1_q   <= 1'b0;
      start_q    <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      hold_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_div_q <= DIV_9600;
      baud_div_q <= DIV_9600;
      busy_q     <= 1'b0;
      rate_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      ready0_q   <= ready0_d;
      ready1_q   <= ready1_d;
      start_q    <= start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      baud_div_q <= baud_div_d;
      busy_q     <= busy_d;
      rate_err_q <= rate_err_d;
    end
  end

  assign oREQ0_READY = ready0_q;
  assign oREQ1_READY = ready1_q;
  assign oTX_START   = start_q;
  assign oTX_DATA    = tx_data_q;
  assign oBAUD_DIV   = baud_div_q;
  assign oGRANT      = grant_q;
  assign oBUSY       = busy_q;
  assign oRATE_ERR   = rate_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: requester drivers fed from
// queues, a TX core model with programmable done delay, a start monitor, and
// a packet-level round-robin reference model.
module tb_uart_tx_scheduler;

  localparam int unsigned TB_CLK_HZ = 50000000;
  localparam int unsigned TB_GAP    = 16;
  localparam int unsigned TB_HOLD   = 1024;

  logic        clk;
  logic        rst;
  logic        iREQ0_VALID, iREQ0_LAST, oREQ0_READY;
  logic [7:0]  iREQ0_DATA;
  logic        iREQ1_VALID, iREQ1_LAST, oREQ1_READY;
  logic [7:0]  iREQ1_DATA;
  logic        oTX_START, iTX_DONE;
  logic [7:0]  oTX_DATA;
  logic [7:0]  iRATE;
  logic        iRATE_VALID;
  logic [15:0] oBAUD_DIV;
  logic [1:0]  oGRANT;
  logic        oBUSY, oRATE_ERR;

  uart_tx_scheduler #(
    .CLK_HZ       (TB_CLK_HZ),
    .GAP_CYCLES   (TB_GAP),
    .MAX_PKT      (64),
    .HOLD_TIMEOUT (TB_HOLD),
    .DIV_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .iREQ0_VALID (iREQ0_VALID),
    .iREQ0_DATA  (iREQ0_DATA),
    .iREQ0_LAST  (iREQ0_LAST),
    .oREQ0_READY (oREQ0_READY),
    .iREQ1_VALID (iREQ1_VALID),
    .iREQ1_DATA  (iREQ1_DATA),
    .iREQ1_LAST  (iREQ1_LAST),
    .oREQ1_READY (oREQ1_READY),
    .oTX_START   (oTX_START),
    .oTX_DATA    (oTX_DATA),
    .iTX_DONE    (iTX_DONE),
    .iRATE       (iRATE),
    .iRATE_VALID (iRATE_VALID),
    .oBAUD_DIV   (oBAUD_DIV),
    .oGRANT      (oGRANT),
    .oBUSY       (oBUSY),
    .oRATE_ERR   (oRATE_ERR)
  );

  typedef struct {
    bit          side;
    bit [7:0]    data;
    int unsigned cyc;
    bit [1:0]    grant;
  } start_t;

  int          checks;
  int          errors;
  int          viol;
  int unsigned cyc;
  int unsigned tx_delay;
  bit [8:0]    drv0[$];
  bit [8:0]    drv1[$];
  bit [8:0]    m0[$];
  bit [8:0]    m1[$];
  bit [8:0]    exp_q[$];
  start_t      mon_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor, TX core model and requester drivers, all evaluated mid-cycle.
  initial begin : env
    int unsigned core_cnt;
    bit          core_busy;
    bit          prev_start;
    logic [15:0] prev_baud;
    core_cnt = 0; core_busy = 0; prev_start = 0; prev_baud = '0;
    iTX_DONE = 0;
    iREQ0_VALID = 0; iREQ0_DATA = '0; iREQ0_LAST = 0;
    iREQ1_VALID = 0; iREQ1_DATA = '0; iREQ1_LAST = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        core_busy = 0; iTX_DONE = 0; prev_start = 0;
      end else begin
        if (oTX_START) mon_q.push_back('{oGRANT[1], oTX_DATA, cyc, oGRANT});
        if (oTX_START && prev_start) viol++;
        if (oREQ0_READY && !oGRANT[0]) viol++;
        if (oREQ1_READY && !oGRANT[1]) viol++;
        if (oTX_START !== (oREQ0_READY | oREQ1_READY)) viol++;
        if ((oBAUD_DIV !== prev_baud) && (oGRANT != 2'b00)) viol++;
        prev_start = oTX_START;
        iTX_DONE = 0;
        if (core_busy) begin
          if (core_cnt <= 1) begin iTX_DONE = 1; core_busy = 0; end
          else core_cnt--;
        end
        if (oTX_START) begin core_busy = 1; core_cnt = tx_delay; end
        if (iREQ0_VALID && oREQ0_READY && drv0.size() > 0) void'(drv0.pop_front());
        if (iREQ1_VALID && oREQ1_READY && drv1.size() > 0) void'(drv1.pop_front());
      end
      prev_baud = oBAUD_DIV;
      iREQ0_VALID = (drv0.size() > 0);
      if (drv0.size() > 0) {iREQ0_LAST, iREQ0_DATA} = drv0[0];
      iREQ1_VALID = (drv1.size() > 0);
      if (drv1.size() > 0) {iREQ1_LAST, iREQ1_DATA} = drv1[0];
    end
  end

  function automatic int unsigned exp_div(input logic [7:0] code);
    int unsigned baud;
    case (code)
      8'h31:        baud = 9600;
      8'h35:        baud = 57600;
      8'h61, 8'h41: baud = 115200;
      default:      baud = 0;
    endcase
    return (baud == 0) ? 0 : TB_CLK_HZ / baud;
  endfunction

  // Packet-level round robin over fully queued streams: ptr side wins a tie,
  // a grant ends on LAST or after 64 bytes, then ptr moves to the other side.
  task automatic model_rr();
    bit       ptr;
    bit       s;
    int       n;
    bit [8:0] b;
    ptr = 0;
    exp_q.delete();
    while (m0.size() > 0 || m1.size() > 0) begin
      if (ptr == 0) s = (m0.size() > 0) ? 1'b0 : 1'b1;
      else          s = (m1.size() > 0) ? 1'b1 : 1'b0;
      n = 0;
      while (1) begin
        b = s ? m1.pop_front() : m0.pop_front();
        exp_q.push_back({s, b[7:0]});
        n++;
        if (b[8] || n == 64) break;
        if (s ? (m1.size() == 0) : (m0.size() == 0)) break;
      end
      ptr = ~s;
    end
  endtask

  task automatic push_pkt(input bit side, input int len);
    bit [8:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), 8'($urandom_range(255))};
      if (side) begin drv1.push_back(b); m1.push_back(b); end
      else      begin drv0.push_back(b); m0.push_back(b); end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    iRATE_VALID = 0;
    iRATE = '0;
    drv0.delete(); drv1.delete(); m0.delete(); m1.delete();
    repeat (3) @(negedge clk);
    mon_q.delete();
    rst = 0;
    @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mon_q.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!oBUSY && drv0.size() == 0 && drv1.size() == 0) begin ok = 1; break; end
    end
  endtask

  task automatic pulse_rate(input logic [7:0] code);
    @(negedge clk);
    iRATE = code;
    iRATE_VALID = 1;
    @(negedge clk);
    iRATE_VALID = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 8;
    if (oGRANT !== 2'b00)    begin errors++; $display("FAIL reset_grant: got %b expected 00", oGRANT); end
    if (oTX_START !== 1'b0)  begin errors++; $display("FAIL reset_start: got %b expected 0", oTX_START); end
    if (oTX_DATA !== 8'h00)  begin errors++; $display("FAIL reset_data: got %h expected 00", oTX_DATA); end
    if (oREQ0_READY !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", oREQ0_READY); end
    if (oREQ1_READY !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", oREQ1_READY); end
    if (oBUSY !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", oBUSY); end
    if (oRATE_ERR !== 1'b0)  begin errors++; $display("FAIL reset_rate_err: got %b expected 0", oRATE_ERR); end
    if (oBAUD_DIV !== 16'(exp_div(8'h31))) begin
      errors++; $display("FAIL reset_baud: got %0d expected %0d", oBAUD_DIV, exp_div(8'h31));
    end
  endtask

  task automatic test_single_packet();
    bit          ok;
    int unsigned n_cyc;
    bit [7:0]    exp_data[3];
    exp_data[0] = 8'h48; exp_data[1] = 8'h49; exp_data[2] = 8'h0A;
    do_reset();
    tx_delay = 100;
    #1;
    drv0.push_back(9'h048); drv0.push_back(9'h049); drv0.push_back(9'h10A);
    @(negedge clk);
    n_cyc = cyc;
    wait_starts(3, 1000, ok);
    if (ok) wait_idle(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got %0d starts expected 3", mon_q.size()); end
    checks++;
    if (mon_q.size() !== 3) begin errors++; $display("FAIL single_count: got %0d expected 3", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++;
      if (mon_q[0].cyc !== n_cyc + 1) begin
        errors++; $display("FAIL single_latency: got %0d expected %0d", mon_q[0].cyc - n_cyc, 1);
      end
    end
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      checks += 2;
      if (mon_q[i].data !== exp_data[i]) begin
        errors++; $display("FAIL single_data[%0d]: got %h expected %h", i, mon_q[i].data, exp_data[i]);
      end
      if (mon_q[i].grant !== 2'b01) begin
        errors++; $display("FAIL single_grant[%0d]: got %b expected 01", i, mon_q[i].grant);
      end
      if (i > 0) begin
        checks++;
        if (mon_q[i].cyc - mon_q[i-1].cyc !== 118) begin
          errors++; $display("FAIL single_spacing[%0d]: got %0d expected 118", i, mon_q[i].cyc - mon_q[i-1].cyc);
        end
      end
    end
    checks++;
    if (oGRANT !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", oGRANT); end
  endtask

  task automatic compare_expected(input string tag);
    // Expected queue comes from the reference model or the test's own list.
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d expected %0d", tag, mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({mon_q[i].side, mon_q[i].data} !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte[%0d]: got side %0d data %h expected side %0d data %h",
                 tag, i, mon_q[i].side, mon_q[i].data, exp_q[i][8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_alternate();
    bit ok;
    do_reset();
    tx_delay = $urandom_range(6, 2);
    for (int i = 0; i < 4; i++) begin push_pkt(0, 1); push_pkt(1, 1); end
    model_rr();
    wait_starts(8, 2000, ok);
    if (ok) wait_idle(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alt_timeout: got %0d starts expected 8", mon_q.size()); end
    compare_expected("alt");
    for (int i = 0; i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].grant !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, mon_q[i].grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int total;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      tx_delay = $urandom_range(10, 1);
      total = 0;
      for (int p = 0; p < 4; p++) begin
        int len;
        len = $urandom_range(5, 1);
        if ($urandom_range(1)) begin push_pkt(0, len); total += len; end
        len = (it == 2 && p == 0) ? 66 : $urandom_range(5, 1);
        if ($urandom_range(1) || (it == 2 && p == 0)) begin push_pkt(1, len); total += len; end
      end
      model_rr();
      wait_starts(total, 6000, ok);
      if (ok) wait_idle(1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout: got %0d starts expected %0d", mon_q.size(), total); end
      compare_expected("rand");
    end
  endtask

  task automatic test_rate();
    bit          ok;
    int unsigned k;
    do_reset();
    tx_delay = 20;
    push_pkt(0, 3);
    wait_starts(1, 200, ok);
    pulse_rate(8'h35);
    checks += 2;
    if (oRATE_ERR !== 1'b0) begin errors++; $display("FAIL rate_good_err: got %b expected 0", oRATE_ERR); end
    if (oBAUD_DIV !== 16'(exp_div(8'h31))) begin
      errors++; $display("FAIL rate_midpkt_hold: got %0d expected %0d", oBAUD_DIV, exp_div(8'h31));
    end
    wait_idle(1000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (oBAUD_DIV !== 16'(exp_div(8'h35))) begin
      errors++; $display("FAIL rate_apply: got %0d expected %0d", oBAUD_DIV, exp_div(8'h35));
    end
    pulse_rate(8'h7A);
    checks++;
    if (oRATE_ERR !== 1'b1) begin errors++; $display("FAIL rate_err_pulse: got %b expected 1", oRATE_ERR); end
    @(negedge clk);
    checks++;
    if (oRATE_ERR !== 1'b0) begin errors++; $display("FAIL rate_err_width: got %b expected 0", oRATE_ERR); end
    repeat (3) @(negedge clk);
    checks++;
    if (oBAUD_DIV !== 16'(exp_div(8'h35))) begin
      errors++; $display("FAIL rate_err_keep: got %0d expected %0d", oBAUD_DIV, exp_div(8'h35));
    end
    // Last request wins across a packet.
    mon_q.delete();
    push_pkt(1, 2);
    wait_starts(1, 200, ok);
    pulse_rate(8'h31);
    pulse_rate(8'h41);
    wait_idle(1000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (oBAUD_DIV !== 16'(exp_div(8'h41))) begin
      errors++; $display("FAIL rate_last_wins: got %0d expected %0d", oBAUD_DIV, exp_div(8'h41));
    end
    // Idle apply timing: old value one cycle after request, new value the next.
    @(negedge clk);
    iRATE = 8'h31; iRATE_VALID = 1;
    @(negedge clk);
    iRATE_VALID = 0;
    checks++;
    if (oBAUD_DIV !== 16'(exp_div(8'h61))) begin
      errors++; $display("FAIL rate_apply_early: got %0d expected %0d", oBAUD_DIV, exp_div(8'h61));
    end
    @(negedge clk);
    checks++;
    if (oBAUD_DIV !== 16'(exp_div(8'h31))) begin
      errors++; $display("FAIL rate_apply_time: got %0d expected %0d", oBAUD_DIV, exp_div(8'h31));
    end
    // Apply takes priority over arbitration in the same IDLE cycle.
    mon_q.delete();
    @(negedge clk);
    iRATE = 8'h35; iRATE_VALID = 1;
    k = cyc;
    #1;
    push_pkt(0, 1);
    @(negedge clk);
    iRATE_VALID = 0;
    wait_starts(1, 100, ok);
    checks++;
    if (!ok || mon_q[0].cyc !== k + 3) begin
      errors++; $display("FAIL rate_priority: got start offset %0d expected 3", ok ? mon_q[0].cyc - k : 0);
    end
    wait_idle(500, ok);
  endtask

  task automatic test_max_pkt();
    bit ok;
    do_reset();
    tx_delay = 3;
    push_pkt(1, 70);
    for (int i = 0; i < 50 && oGRANT !== 2'b10; i++) @(negedge clk);
    checks++;
    if (oGRANT !== 2'b10) begin errors++; $display("FAIL max_first_grant: got %b expected 10", oGRANT); end
    push_pkt(0, 1);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, m1[i][7:0]});
    exp_q.push_back({1'b0, m0[0][7:0]});
    for (int i = 64; i < 70; i++) exp_q.push_back({1'b1, m1[i][7:0]});
    wait_starts(71, 4000, ok);
    if (ok) wait_idle(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL max_timeout: got %0d starts expected 71", mon_q.size()); end
    compare_expected("max");
  endtask

  task automatic test_timeout();
    bit          ok;
    int unsigned target;
    do_reset();
    tx_delay = 10;
    drv0.push_back({1'b0, 8'($urandom_range(255))});
    wait_starts(1, 100, ok);
    target = mon_q[0].cyc + tx_delay + TB_GAP + TB_HOLD;
    for (int i = 0; i < 2000 && cyc < target; i++) @(negedge clk);
    checks += 2;
    if (oGRANT !== 2'b01) begin errors++; $display("FAIL hold_before_grant: got %b expected 01", oGRANT); end
    if (oBUSY !== 1'b1)   begin errors++; $display("FAIL hold_before_busy: got %b expected 1", oBUSY); end
    @(negedge clk);
    checks += 2;
    if (oGRANT !== 2'b00) begin errors++; $display("FAIL hold_release_grant: got %b expected 00", oGRANT); end
    if (oBUSY !== 1'b0)   begin errors++; $display("FAIL hold_release_busy: got %b expected 0", oBUSY); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    tx_delay = 50;
    push_pkt(0, 3);
    wait_starts(1, 100, ok);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    checks += 6;
    if (oGRANT !== 2'b00)   begin errors++; $display("FAIL rstw_grant: got %b expected 00", oGRANT); end
    if (oBUSY !== 1'b0)     begin errors++; $display("FAIL rstw_busy: got %b expected 0", oBUSY); end
    if (oTX_DATA !== 8'h00) begin errors++; $display("FAIL rstw_data: got %h expected 00", oTX_DATA); end
    if (oTX_START !== 1'b0) begin errors++; $display("FAIL rstw_start: got %b expected 0", oTX_START); end
    if ((oREQ0_READY | oREQ1_READY) !== 1'b0) begin errors++; $display("FAIL rstw_ready: got %b expected 0", oREQ0_READY | oREQ1_READY); end
    if (oBAUD_DIV !== 16'(exp_div(8'h31))) begin errors++; $display("FAIL rstw_baud: got %0d expected %0d", oBAUD_DIV, exp_div(8'h31)); end
    drv0.delete(); m0.delete(); m1.delete();
    @(negedge clk);
    mon_q.delete();
    rst = 0;
    push_pkt(1, 2);
    model_rr();
    wait_starts(2, 500, ok);
    if (ok) wait_idle(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstw_timeout: got %0d starts expected 2", mon_q.size()); end
    compare_expected("rstw");
  endtask

  initial begin
    checks = 0; errors = 0; viol = 0;
    tx_delay = 10;
    rst = 1; iRATE = '0; iRATE_VALID = 0;
    test_reset();
    test_single_packet();
    test_alternate();
    test_random();
    test_rate();
    test_max_pkt();
    test_timeout();
    test_reset_mid_wait();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL protocol_invariants: got %0d violations expected 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
